control_sequencer: RTL and testbench

- Multi-cycle instruction fetch/decode/sequencing unit directly upstream of the register-file/function-unit datapath.
- Fetches 16-bit instructions from instruction memory over a REQ/ACK handshake and holds them in IR.
- Per instruction, drives the datapath control word CTRWRD, the constant input Cin and the data-memory write strobe MW.
- Consumes datapath flags V/C/N/Z and busA (Adrout) for conditional branches and register-indirect jumps.

---
 rtl/cs_pkg.sv | 52 +++++
 rtl/control_sequencer_if.sv | 26 ++
 rtl/cs_decode.sv | 82 ++++++++
 rtl/control_sequencer.sv | 101 ++++++++++
 tb/tb_control_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cs_pkg.sv
// Shared definitions for the control sequencer: opcodes, FS codes,
// FSM states, instruction classes and control-word field positions.
package cs_pkg;

    localparam logic [6:0] OP_LD   = 7'b0010000;
    localparam logic [6:0] OP_ST   = 7'b0100000;
    localparam logic [6:0] OP_ADI  = 7'b1000010;
    localparam logic [6:0] OP_LDI  = 7'b1001100;
    localparam logic [6:0] OP_BRZ  = 7'b1100000;
    localparam logic [6:0] OP_BRN  = 7'b1100001;
    localparam logic [6:0] OP_JMP  = 7'b1110000;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    localparam logic [3:0] FS_A    = 4'b0000;
    localparam logic [3:0] FS_INC  = 4'b0001;
    localparam logic [3:0] FS_ADD  = 4'b0010;
    localparam logic [3:0] FS_SUB  = 4'b0101;
    localparam logic [3:0] FS_DEC  = 4'b0110;
    localparam logic [3:0] FS_AND  = 4'b1000;
    localparam logic [3:0] FS_OR   = 4'b1001;
    localparam logic [3:0] FS_XOR  = 4'b1010;
    localparam logic [3:0] FS_NOT  = 4'b1011;
    localparam logic [3:0] FS_B    = 4'b1100;
    localparam logic [3:0] FS_SHR  = 4'b1101;
    localparam logic [3:0] FS_SHL  = 4'b1110;

    localparam int CW_DA = 13;
    localparam int CW_AA = 10;
    localparam int CW_BA = 7;
    localparam int CW_MB = 6;
    localparam int CW_FS = 2;
    localparam int CW_MD = 1;
    localparam int CW_RW = 0;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_BR_EVAL,
        S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_MEM,
        CL_IMM,
        CL_BRANCH,
        CL_JMP,
        CL_HALT
    } cls_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-memory handshake and datapath control/flag bundle
// between the sequencer (master) and its environment (slave).
interface control_sequencer_if;
    logic [15:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [15:0] IMEM_DATA;
    logic [15:0] CTRWRD;
    logic [15:0] Cin;
    logic        MW;
    logic [15:0] ADRIN;
    logic        V;
    logic        C;
    logic        N;
    logic        Z;

    modport master (
        output IMEM_ADDR, IMEM_REQ, CTRWRD, Cin, MW,
        input  IMEM_ACK, IMEM_DATA, ADRIN, V, C, N, Z
    );

    modport slave (
        input  IMEM_ADDR, IMEM_REQ, CTRWRD, Cin, MW,
        output IMEM_ACK, IMEM_DATA, ADRIN, V, C, N, Z
    );
endinterface

// File: rtl/cs_decode.sv
// Combinational instruction decode: IR -> control word, constant,
// memory-write strobe and instruction class.
module cs_decode
    import cs_pkg::*;
(
    input  logic [15:0] ir,
    output logic [15:0] ctrwrd,
    output logic [15:0] cin,
    output logic        mw,
    output cls_t        cls
);

    logic [6:0] op;
    logic       mb;
    logic       md;
    logic       rw;
    logic       fields;
    logic [3:0] fs;

    assign op = ir[15:9];

    always_comb begin
        mb     = 1'b0;
        md     = 1'b0;
        rw     = 1'b0;
        fs     = FS_A;
        fields = 1'b1;
        cin    = '0;
        mw     = 1'b0;
        cls    = CL_NOP;
        if (op[6:4] == 3'b000) begin
            cls = CL_ALU;
            fs  = op[3:0];
            rw  = 1'b1;
        end else begin
            unique case (op)
                OP_LD: begin
                    cls = CL_MEM;
                    md  = 1'b1;
                    rw  = 1'b1;
                end
                OP_ST: begin
                    cls = CL_MEM;
                    mw  = 1'b1;
                end
                OP_ADI: begin
                    cls = CL_IMM;
                    mb  = 1'b1;
                    fs  = FS_ADD;
                    rw  = 1'b1;
                    cin = {13'b0, ir[2:0]};
                end
                OP_LDI: begin
                    cls = CL_IMM;
                    mb  = 1'b1;
                    fs  = FS_B;
                    rw  = 1'b1;
                    cin = {13'b0, ir[2:0]};
                end
                OP_BRZ, OP_BRN: cls = CL_BRANCH;
                OP_JMP:         cls = CL_JMP;
                OP_HALT: begin
                    cls    = CL_HALT;
                    fields = 1'b0;
                end
                default: fields = 1'b0;
            endcase
        end

        ctrwrd = '0;
        if (fields) begin
            ctrwrd[CW_DA +: 3] = ir[8:6];
            ctrwrd[CW_AA +: 3] = ir[5:3];
            ctrwrd[CW_BA +: 3] = ir[2:0];
            ctrwrd[CW_MB]      = mb;
            ctrwrd[CW_FS +: 4] = fs;
            ctrwrd[CW_MD]      = md;
            ctrwrd[CW_RW]      = rw;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: PC, IR and the FETCH/EXEC/BR_EVAL/HALTED
// FSM driving the datapath control word.
module control_sequencer
    import cs_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    control_sequencer_if.master  bus
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_nxt;
    logic [15:0] ir;
    logic [15:0] ir_nxt;

    logic [15:0] dec_cw;
    logic [15:0] dec_cin;
    logic        dec_mw;
    cls_t        dec_cls;

    logic        req;
    logic [15:0] cw_o;
    logic [15:0] cin_o;
    logic        mw_o;
    logic        take;
    logic [15:0] br_off;
    logic        unused_vc;

    cs_decode u_decode (
        .ir     (ir),
        .ctrwrd (dec_cw),
        .cin    (dec_cin),
        .mw     (dec_mw),
        .cls    (dec_cls)
    );

    // OP bit 0 separates BRN from BRZ
    assign take      = ir[9] ? bus.N : bus.Z;
    assign br_off    = {{10{ir[8]}}, ir[8:6], ir[2:0]};
    assign unused_vc = bus.V ^ bus.C;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        req       = 1'b0;
        cw_o      = '0;
        cin_o     = '0;
        mw_o      = 1'b0;
        unique case (state)
            S_FETCH: begin
                req = 1'b1;
                if (bus.IMEM_ACK) begin
                    ir_nxt    = bus.IMEM_DATA;
                    pc_nxt    = pc + 16'd1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                cw_o      = dec_cw;
                cin_o     = dec_cin;
                mw_o      = dec_mw;
                state_nxt = S_FETCH;
                if (dec_cls == CL_BRANCH) state_nxt = S_BR_EVAL;
                if (dec_cls == CL_HALT)   state_nxt = S_HALTED;
                if (dec_cls == CL_JMP)    pc_nxt    = bus.ADRIN;
            end
            S_BR_EVAL: begin
                // hold the EXEC word so flags stay valid for either flag style
                cw_o      = dec_cw;
                cin_o     = dec_cin;
                state_nxt = S_FETCH;
                if (take) pc_nxt = pc + br_off;
            end
            default: ;
        endcase
    end

    assign bus.IMEM_ADDR = RESET ? pc : RESET_PC;
    assign bus.IMEM_REQ  = RESET & req;
    assign bus.CTRWRD    = RESET ? cw_o : '0;
    assign bus.Cin       = RESET ? cin_o : '0;
    assign bus.MW        = RESET & mw_o;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against an
// instruction-level reference model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer #(.RESET_PC(16'h0000)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected EXEC-cycle outputs from the instruction-set tables
    task automatic model(input logic [15:0] ins, output logic [15:0] cw,
                         output logic [15:0] cin, output logic mw);
        int op;
        int mb;
        int fs;
        int md;
        int rw;
        bit regs;
        op = int'(ins[15:9]);
        mb = 0; fs = 0; md = 0; rw = 0; regs = 1'b1;
        cin = '0;
        mw = 1'b0;
        if (op < 16) begin
            fs = op; rw = 1;
        end else begin
            case (op)
                'h10: begin md = 1; rw = 1; end
                'h20: mw = 1'b1;
                'h42: begin mb = 1; fs = 2; rw = 1; cin = {13'b0, ins[2:0]}; end
                'h4C: begin mb = 1; fs = 12; rw = 1; cin = {13'b0, ins[2:0]}; end
                'h60, 'h61, 'h70: ;
                default: regs = 1'b0;
            endcase
        end
        cw = regs ? 16'(int'(ins[8:0]) * 128 + mb * 64 + fs * 4 + md * 2 + rw)
                  : 16'h0000;
    endtask

    task automatic run_instr(input logic [15:0] ins, input int waits,
                             input logic z, input logic n,
                             input logic [15:0] adrin);
        logic [15:0] cw;
        logic [15:0] cin;
        logic        mw;
        logic [5:0]  off;
        int          op;
        model(ins, cw, cin, mw);
        op = int'(ins[15:9]);
        for (int i = 0; i < waits; i++) begin
            bus.IMEM_ACK  = 1'b0;
            bus.IMEM_DATA = 16'hFE00;
            chk("wait_req", 16'(bus.IMEM_REQ), 16'h0001);
            chk("wait_addr", bus.IMEM_ADDR, exp_pc);
            chk("wait_cw", bus.CTRWRD, 16'h0000);
            step();
        end
        bus.IMEM_ACK  = 1'b1;
        bus.IMEM_DATA = ins;
        chk("fetch_req", 16'(bus.IMEM_REQ), 16'h0001);
        chk("fetch_addr", bus.IMEM_ADDR, exp_pc);
        chk("fetch_mw", 16'(bus.MW), 16'h0000);
        step();
        exp_pc = exp_pc + 16'd1;
        bus.IMEM_ACK  = 1'($urandom_range(0, 1));
        bus.IMEM_DATA = 16'($urandom);
        bus.Z = z;
        bus.N = n;
        bus.ADRIN = adrin;
        chk("exec_cw", bus.CTRWRD, cw);
        chk("exec_cin", bus.Cin, cin);
        chk("exec_mw", 16'(bus.MW), 16'(mw));
        chk("exec_req", 16'(bus.IMEM_REQ), 16'h0000);
        step();
        if (op == 'h70) exp_pc = adrin;
        if (op == 'h60 || op == 'h61) begin
            chk("br_cw", bus.CTRWRD, cw);
            chk("br_mw", 16'(bus.MW), 16'h0000);
            chk("br_req", 16'(bus.IMEM_REQ), 16'h0000);
            off = {ins[8:6], ins[2:0]};
            if ((op == 'h60) ? z : n)
                exp_pc = exp_pc + {{10{off[5]}}, off};
            step();
        end
        bus.IMEM_ACK = 1'b0;
    endtask

    initial begin
        logic [6:0]  op;
        logic [15:0] ins;
        bus.IMEM_ACK  = 1'b1;
        bus.IMEM_DATA = 16'h04CA;
        bus.ADRIN = '0;
        bus.V = 1'b0; bus.C = 1'b0; bus.N = 1'b0; bus.Z = 1'b0;
        exp_pc = 16'h0000;

        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_req", 16'(bus.IMEM_REQ), 16'h0000);
            chk("rst_cw", bus.CTRWRD, 16'h0000);
            chk("rst_mw", 16'(bus.MW), 16'h0000);
            chk("rst_addr", bus.IMEM_ADDR, 16'h0000);
        end
        rst_n = 1'b1;
        bus.IMEM_ACK = 1'b0;
        #1;
        chk("post_rst_req", 16'(bus.IMEM_REQ), 16'h0001);
        chk("post_rst_addr", bus.IMEM_ADDR, 16'h0000);

        run_instr(16'h04CA, 0, 1'b0, 1'b0, 16'h0000);
        run_instr(16'h8485, 0, 1'b0, 1'b0, 16'h0000);
        run_instr(16'h9847, 3, 1'b0, 1'b0, 16'h0000);
        run_instr(16'hE008, 0, 1'b0, 1'b0, 16'h0010);
        run_instr(16'hC1C6, 0, 1'b1, 1'b0, 16'h0000);
        chk("brz_taken", bus.IMEM_ADDR, 16'h000F);
        run_instr(16'hFC00, 1, 1'b0, 1'b0, 16'h0000);
        run_instr(16'hC1C6, 0, 1'b0, 1'b1, 16'h0000);
        chk("brz_not_taken", bus.IMEM_ADDR, 16'h0011);
        run_instr(16'hC3C6, 0, 1'b0, 1'b1, 16'h0000);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 8))
                0: op = 7'($urandom_range(0, 15));
                1: op = 7'h10;
                2: op = 7'h20;
                3: op = 7'h42;
                4: op = 7'h4C;
                5: op = 7'h60;
                6: op = 7'h61;
                7: op = 7'h70;
                default: op = 7'($urandom_range(0, 126));
            endcase
            ins = {op, 9'($urandom)};
            run_instr(ins, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'($urandom));
        end

        run_instr(16'h400A, 0, 1'b0, 1'b0, 16'h0000);
        chk("st_mw_after", 16'(bus.MW), 16'h0000);
        run_instr(16'hFE00, 0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            bus.IMEM_ACK  = 1'b1;
            bus.IMEM_DATA = 16'h04CA;
            chk("halt_req", 16'(bus.IMEM_REQ), 16'h0000);
            chk("halt_cw", bus.CTRWRD, 16'h0000);
            chk("halt_mw", 16'(bus.MW), 16'h0000);
            step();
        end

        rst_n = 1'b0;
        bus.IMEM_ACK = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        exp_pc = 16'h0000;
        run_instr(16'h04CA, 0, 1'b0, 1'b0, 16'h0000);

        bus.IMEM_ACK  = 1'b1;
        bus.IMEM_DATA = 16'h400A;
        step();
        bus.IMEM_ACK = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_mw", 16'(bus.MW), 16'h0000);
        chk("abort_cw", bus.CTRWRD, 16'h0000);
        step();
        rst_n = 1'b1;
        #1;
        exp_pc = 16'h0000;
        chk("abort_addr", bus.IMEM_ADDR, 16'h0000);
        run_instr(16'h8485, 1, 1'b0, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
